// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, sign_mask
// width codes and the LED MMIO address (used when DATA_MEM_LED_MMIO_EN is defined).
package data_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;

  localparam logic [31:0] LED_MMIO_ADDR = 32'h0000_2000;

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane logic: extracts/extends load data, merges store data into
// the fetched word and flags misaligned half/word accesses.
module data_mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [3:0]  sign_mask,
  input  logic [31:0] write_data,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        misaligned
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [15:0] half;

  assign shamt   = {byte_off, 3'b000};
  assign shifted = word >> shamt;
  assign half    = byte_off[1] ? word[31:16] : word[15:0];

  // Unrecognised width codes behave as a word access.
  always_comb begin
    load_val   = word;
    store_word = write_data;
    misaligned = 1'b0;
    case (sign_mask[2:0])
      MASK_BYTE: begin
        load_val   = {{24{sign_mask[3] & shifted[7]}}, shifted[7:0]};
        store_word = (word & ~(32'h0000_00FF << shamt)) |
                     ({24'b0, write_data[7:0]} << shamt);
      end
      MASK_HALF: begin
        misaligned = byte_off[0];
        load_val   = {{16{sign_mask[3] & half[15]}}, half};
        store_word = byte_off[1] ? {write_data[15:0], word[15:0]}
                                 : {word[31:16], write_data[15:0]};
      end
      default: begin
        misaligned = (byte_off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores on a word-wide block
// RAM via an IDLE/READ/WRITE read-modify-write FSM. LED MMIO: DATA_MEM_LED_MMIO_EN.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        clk_stall,
  output logic        misalign_err,
  output logic [7:0]  led
);

  state_t             state;
  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        ram_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [1:0]         off_q;
  logic [31:0]        wdata_q;
  logic [3:0]         mask_q;
  logic               store_q;
  logic               mmio_q;
  logic [31:0]        merged_q;

  logic               request;
  logic               mmio_req;
  logic [ADDR_W-1:0]  req_idx;
  logic [31:0]        align_word;
  logic [31:0]        load_val;
  logic [31:0]        store_word;
  logic               misaligned;
  logic               unused_addr_bits;

  assign request          = memread | memwrite;
  assign req_idx          = addr[ADDR_W+1:2];
  assign unused_addr_bits = ^addr[31:ADDR_W+2];
  assign clk_stall        = !rst && ((state == IDLE && request) || state != IDLE);
  assign align_word       = mmio_q ? {24'b0, led} : ram_q;

`ifdef DATA_MEM_LED_MMIO_EN
  assign mmio_req = (addr[31:2] == LED_MMIO_ADDR[31:2]);

  // Only byte stores reach the LED register; wider stores to it are dropped.
  always_ff @(posedge clk) begin
    if (rst)
      led <= '0;
    else if (state == WRITE && mmio_q && mask_q[2:0] == MASK_BYTE)
      led <= wdata_q[7:0];
  end
`else
  assign mmio_req = 1'b0;
  assign led      = '0;
`endif

  data_mem_lane_align u_align (
    .word       (align_word),
    .byte_off   (off_q),
    .sign_mask  (mask_q),
    .write_data (wdata_q),
    .load_val   (load_val),
    .store_word (store_word),
    .misaligned (misaligned)
  );

  // Block RAM: the read is only issued when a request is accepted, so ram_q
  // stays stable through READ and WRITE.
  always_ff @(posedge clk) begin
    if (state == IDLE && request)
      ram_q <= mem[req_idx];
    if (state == WRITE && !rst && !mmio_q)
      mem[idx_q] <= merged_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      read_data    <= '0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            idx_q   <= req_idx;
            off_q   <= addr[1:0];
            wdata_q <= write_data;
            mask_q  <= sign_mask;
            store_q <= memwrite;
            mmio_q  <= mmio_req;
            state   <= READ;
          end
        end
        READ: begin
          if (misaligned)
            misalign_err <= 1'b1;
          if (store_q) begin
            merged_q <= store_word;
            state    <= misaligned ? IDLE : WRITE;
          end else begin
            read_data <= misaligned ? 32'h0 : load_val;
            state     <= IDLE;
          end
        end
        WRITE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (covers the LED MMIO build
// when DATA_MEM_LED_MMIO_EN is defined).
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;
  logic        misalign_err;
  logic [7:0]  led;

  int checks   = 0;
  int failures = 0;
  int stalls;

  data_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_data   (write_data),
    .memwrite     (memwrite),
    .memread      (memread),
    .sign_mask    (sign_mask),
    .read_data    (read_data),
    .clk_stall    (clk_stall),
    .misalign_err (misalign_err),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issues one request and counts the cycles clk_stall stays high (bounded).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] m, input logic rd,
                               input logic wr, output int n);
    @(negedge clk);
    addr = a; write_data = wd; sign_mask = m; memread = rd; memwrite = wr;
    n = 0;
    #1;
    while (clk_stall && n < 10) begin
      n++;
      @(posedge clk);
      #1;
      memread  = 1'b0;
      memwrite = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    $display("[TB] starting data_mem_ctrl directed test");
    rst = 1'b1; addr = '0; write_data = '0; sign_mask = 4'b0111;
    memread = 1'b0; memwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_read_data", read_data, 32'h0);
    checkOutput("reset_clk_stall", {31'b0, clk_stall}, 32'h0);
    checkOutput("reset_misalign", {31'b0, misalign_err}, 32'h0);
    checkOutput("reset_led", {24'b0, led}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Word round trip
    applyStimulus(32'h10, 32'hDEADBEEF, 4'b0111, 1'b0, 1'b1, stalls);
    checkOutput("word_store_stalls", 32'(stalls), 32'd3);
    applyStimulus(32'h10, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("word_load_stalls", 32'(stalls), 32'd2);
    checkOutput("word_load", read_data, 32'hDEADBEEF);

    // Byte merge; upper write_data bits must be ignored
    applyStimulus(32'h12, 32'hAAAAAA55, 4'b0001, 1'b0, 1'b1, stalls);
    checkOutput("store_holds_read_data", read_data, 32'hDEADBEEF);
    applyStimulus(32'h10, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("byte_merge_word", read_data, 32'hDE55BEEF);
    applyStimulus(32'h13, 32'h0, 4'b1001, 1'b1, 1'b0, stalls);
    checkOutput("byte_load_signed", read_data, 32'hFFFFFFDE);
    applyStimulus(32'h13, 32'h0, 4'b0001, 1'b1, 1'b0, stalls);
    checkOutput("byte_load_unsigned", read_data, 32'h000000DE);
    applyStimulus(32'h11, 32'h0, 4'b1001, 1'b1, 1'b0, stalls);
    checkOutput("byte_load_lane1", read_data, 32'hFFFFFFBE);

    // Halfwords, both halves
    applyStimulus(32'h20, 32'h12348001, 4'b0011, 1'b0, 1'b1, stalls);
    applyStimulus(32'h20, 32'h0, 4'b1011, 1'b1, 1'b0, stalls);
    checkOutput("half_load_signed", read_data, 32'hFFFF8001);
    applyStimulus(32'h20, 32'h0, 4'b0011, 1'b1, 1'b0, stalls);
    checkOutput("half_load_unsigned", read_data, 32'h00008001);
    applyStimulus(32'h22, 32'hFFFF7FFE, 4'b0011, 1'b0, 1'b1, stalls);
    applyStimulus(32'h20, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("half_merge_word", read_data, 32'h7FFE8001);
    applyStimulus(32'h22, 32'h0, 4'b1011, 1'b1, 1'b0, stalls);
    checkOutput("half_upper_signed", read_data, 32'h00007FFE);

    // Misalignment
    checkOutput("misalign_clear_before", {31'b0, misalign_err}, 32'h0);
    applyStimulus(32'h21, 32'hDEADBEEF, 4'b0111, 1'b0, 1'b1, stalls);
    checkOutput("misalign_store_stalls", 32'(stalls), 32'd2);
    checkOutput("misalign_set", {31'b0, misalign_err}, 32'h1);
    applyStimulus(32'h20, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("misalign_not_committed", read_data, 32'h7FFE8001);
    applyStimulus(32'h21, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("misalign_load_zero", read_data, 32'h0);
    applyStimulus(32'h20, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    applyStimulus(32'h23, 32'h0, 4'b1011, 1'b1, 1'b0, stalls);
    checkOutput("misalign_half_zero", read_data, 32'h0);
    checkOutput("misalign_sticky", {31'b0, misalign_err}, 32'h1);

    // memread and memwrite together act as a store
    applyStimulus(32'h40, 32'hCAFEF00D, 4'b0111, 1'b1, 1'b1, stalls);
    checkOutput("both_stalls", 32'(stalls), 32'd3);
    checkOutput("both_no_read_update", read_data, 32'h0);
    applyStimulus(32'h40, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("both_committed", read_data, 32'hCAFEF00D);

    // Address aliasing modulo 4 KiB
    applyStimulus(32'h0000_1010, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("alias_load", read_data, 32'hDE55BEEF);

    // Reset during the WRITE cycle of a store
    applyStimulus(32'h30, 32'h0, 4'b0111, 1'b0, 1'b1, stalls);
    @(negedge clk);
    addr = 32'h30; write_data = 32'h12345678; sign_mask = 4'b0111; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
    @(posedge clk); #1;
    checkOutput("write_cycle_stall", {31'b0, clk_stall}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_mid_stall", {31'b0, clk_stall}, 32'h0);
    checkOutput("reset_clears_misalign", {31'b0, misalign_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h10, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    applyStimulus(32'h30, 32'h0, 4'b0111, 1'b1, 1'b0, stalls);
    checkOutput("reset_mid_not_committed", read_data, 32'h0);

    // LED MMIO at 0x2000 (aliases RAM word 0 when the feature is off)
    applyStimulus(32'h0, 32'h0, 4'b0111, 1'b0, 1'b1, stalls);
    applyStimulus(32'h2000, 32'h000000A5, 4'b0001, 1'b0, 1'b1, stalls);
    checkOutput("mmio_store_stalls", 32'(stalls), 32'd3);
    applyStimulus(32'h2000, 32'h0, 4'b1001, 1'b1, 1'b0, stalls);
    checkOutput("mmio_load_signed", read_data, 32'hFFFFFFA5);
`ifdef DATA_MEM_LED_MMIO_EN
    checkOutput("mmio_led", {24'b0, led}, 32'h000000A5);
    applyStimulus(32'h0, 32'h0, 4'b0001, 1'b1, 1'b0, stalls);
    checkOutput("mmio_ram_untouched", read_data, 32'h0);
    applyStimulus(32'h2002, 32'h0000003C, 4'b0001, 1'b0, 1'b1, stalls);
    checkOutput("mmio_led_lane2", {24'b0, led}, 32'h0000003C);
`else
    checkOutput("led_tied_zero", {24'b0, led}, 32'h0);
    applyStimulus(32'h0, 32'h0, 4'b0001, 1'b1, 1'b0, stalls);
    checkOutput("mmio_alias_ram", read_data, 32'h000000A5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
